// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory responder.
//   state_e       : responder FSM states (IDLE, WAIT, RESP)
//   CNT_W         : width of the wait-state down-counter
//   MMIO_SW_ADDR  : switch input register (read-only), used with DMEM_MMIO_EN
//   MMIO_HEX_ADDR : debug display register (read/write), used with DMEM_MMIO_EN
package dmem_pkg;

  localparam int          CNT_W         = 4;
  localparam logic [31:0] MMIO_SW_ADDR  = 32'hFFFF_0000;
  localparam logic [31:0] MMIO_HEX_ADDR = 32'hFFFF_0004;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_if.sv
// dmem_if: load/store request/response bundle between the Memory stage and
// the data-memory responder.
//   req_valid/req_ready : request handshake (taken when both are high)
//   req_we/addr/wdata   : request payload (write flag, byte address, data)
//   rsp_valid           : single-cycle response pulse
//   rsp_rdata/rsp_err   : response payload, meaningful only with rsp_valid
//   busy                : a transaction is outstanding (stall hint)
// Modports: master = processor side, slave = responder side.
interface dmem_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              busy;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/dmem_array.sv
// dmem_array: synchronous single-port DEPTH x DATA_W storage.
//   clk, reset : clock and asynchronous active-low reset (read register only)
//   we, re     : write enable / read enable, mutually exclusive per cycle
//   addr       : word index
//   wdata      : write data
//   rdata      : registered read data, updated only on a read-enabled edge
module dmem_array #(
  parameter  int DEPTH  = 64,
  parameter  int DATA_W = 32,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the storage array has no reset; clearing it would force it into
  // flops instead of a RAM macro, and software never relies on its contents.
  // NOTE: sequential state is assigned with <= so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side end of the processor's load/store interface.
// Accepts one word request at a time, waits WAIT_CYCLES, then pulses a
// one-cycle response carrying read data or an error flag.
//   clk, reset : clock and asynchronous active-low reset
//   bus        : dmem_if.slave request/response bundle plus busy
//   sw_in      : switch inputs, readable at MMIO_SW_ADDR
//   hex_out    : debug display register at MMIO_HEX_ADDR
// Build option: define DMEM_MMIO_EN to map the two MMIO registers; without
// it sw_in is ignored, hex_out is 0 and both addresses report an error.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2,
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32
) (
  input  logic        clk,
  input  logic        reset,
  dmem_if.slave       bus,
  input  logic [3:0]  sw_in,
  output logic [31:0] hex_out
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LOAD =
    (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  state_e            state;
  logic [CNT_W-1:0]  cnt;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rsp_err_q;
  logic              use_arr_q;
  logic [DATA_W-1:0] rsp_data_q;

  logic              accept;
  logic              enter_resp;
  logic              cur_we;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic              in_range;
  logic              is_sw;
  logic              is_hex;
  logic              acc_err;
  logic              arr_we;
  logic              arr_re;
  logic [DATA_W-1:0] arr_rdata;
  logic [DATA_W-1:0] mmio_rdata;
  logic [31:0]       hex_q;

  assign bus.req_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = use_arr_q ? arr_rdata : rsp_data_q;

  assign accept     = bus.req_valid && bus.req_ready;
  // With zero wait states the commit edge is the accept edge itself.
  assign enter_resp = (state == IDLE && accept && WAIT_CYCLES == 0) ||
                      (state == WAIT && cnt == '0);

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    cur_we     = we_q;
    cur_addr   = addr_q;
    cur_wdata  = wdata_q;
    is_sw      = 1'b0;
    is_hex     = 1'b0;
    mmio_rdata = '0;
    // In IDLE the request has not been latched yet, so decode the live bus.
    if (state == IDLE) begin
      cur_we    = bus.req_we;
      cur_addr  = bus.req_addr;
      cur_wdata = bus.req_wdata;
    end
    in_range = (cur_addr >> 2) < ADDR_W'(DEPTH);
`ifdef DMEM_MMIO_EN
    is_sw  = (cur_addr == MMIO_SW_ADDR);
    is_hex = (cur_addr == MMIO_HEX_ADDR);
    if (is_sw)       mmio_rdata = {28'b0, sw_in};
    else if (is_hex) mmio_rdata = hex_q;
`endif
    // The switch register is read-only, so a write there is an error.
    acc_err = (cur_addr[1:0] != 2'b00) ||
              !(in_range || is_hex || (is_sw && !cur_we));
    arr_we  = enter_resp && !acc_err && in_range &&  cur_we;
    arr_re  = enter_resp && !acc_err && in_range && !cur_we;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rsp_err_q  <= 1'b0;
      use_arr_q  <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      if (enter_resp) begin
        rsp_err_q  <= acc_err;
        use_arr_q  <= arr_re;
        rsp_data_q <= (!acc_err && !cur_we && !in_range) ? mmio_rdata : '0;
      end
      case (state)
        IDLE: if (accept) begin
          we_q    <= bus.req_we;
          addr_q  <= bus.req_addr;
          wdata_q <= bus.req_wdata;
          if (WAIT_CYCLES == 0) begin
            state <= RESP;
          end else begin
            state <= WAIT;
            cnt   <= CNT_LOAD;
          end
        end
        WAIT: begin
          if (cnt == '0) state <= RESP;
          else           cnt   <= cnt - 1'b1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DMEM_MMIO_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) hex_q <= '0;
    else if (enter_resp && cur_we && is_hex && !acc_err) hex_q <= cur_wdata;
  end
  assign hex_out = hex_q;
`else
  logic unused_sw;
  assign hex_q     = '0;
  assign hex_out   = '0;
  assign unused_sw = ^{sw_in, hex_q};
`endif

  dmem_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .we    (arr_we),
    .re    (arr_re),
    .addr  (cur_addr[AW+1:2]),
    .wdata (cur_wdata),
    .rdata (arr_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed self-checking bench for dmem_responder.
// dut_a runs with WAIT_CYCLES=2, dut_b with WAIT_CYCLES=0; both DEPTH=64.
// Inputs change on the falling edge, outputs are sampled on the falling edge.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  sw_in = 4'b0;
  logic        valid_a = 1'b0;
  logic        valid_b = 1'b0;
  logic        t_we = 1'b0;
  logic [31:0] t_addr = '0;
  logic [31:0] t_wdata = '0;
  logic [31:0] hex_a;
  logic [31:0] hex_b;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  dmem_if #(.ADDR_W(32), .DATA_W(32)) if_a ();
  dmem_if #(.ADDR_W(32), .DATA_W(32)) if_b ();

  assign if_a.req_valid = valid_a;
  assign if_a.req_we    = t_we;
  assign if_a.req_addr  = t_addr;
  assign if_a.req_wdata = t_wdata;
  assign if_b.req_valid = valid_b;
  assign if_b.req_we    = t_we;
  assign if_b.req_addr  = t_addr;
  assign if_b.req_wdata = t_wdata;

  dmem_responder #(.DEPTH(64), .WAIT_CYCLES(2), .DATA_W(32), .ADDR_W(32)) dut_a (
    .clk(clk), .reset(reset), .bus(if_a), .sw_in(sw_in), .hex_out(hex_a)
  );

  dmem_responder #(.DEPTH(64), .WAIT_CYCLES(0), .DATA_W(32), .ADDR_W(32)) dut_b (
    .clk(clk), .reset(reset), .bus(if_b), .sw_in(sw_in), .hex_out(hex_b)
  );

  // One transaction: present it on a falling edge, wait for ready, count
  // falling edges after the accepting rising edge until rsp_valid is seen.
  task automatic txn(input bit sel, input logic we_i, input logic [31:0] addr_i,
                     input logic [31:0] wdata_i, output logic [31:0] rd,
                     output logic er, output int lat);
    bit got = 0;
    int n = 0;
    @(negedge clk);
    t_we = we_i; t_addr = addr_i; t_wdata = wdata_i;
    if (sel) valid_b = 1'b1; else valid_a = 1'b1;
    while (!(sel ? if_b.req_ready : if_a.req_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    lat = 0; rd = 'x; er = 1'bx;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      lat++;
      valid_a = 1'b0; valid_b = 1'b0;
      if (sel ? if_b.rsp_valid : if_a.rsp_valid) begin
        got = 1;
        rd  = sel ? if_b.rsp_rdata : if_a.rsp_rdata;
        er  = sel ? if_b.rsp_err : if_a.rsp_err;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL txn_timeout addr=%h: no rsp_valid seen, required one", addr_i);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({if_a.req_ready, if_a.busy, if_a.rsp_valid, if_a.rsp_err} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_ctrl got {rdy,busy,rv,err}=%b need 1000",
               {if_a.req_ready, if_a.busy, if_a.rsp_valid, if_a.rsp_err});
    end
    checks++;
    if (if_a.rsp_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_rdata got %h need 0", if_a.rsp_rdata);
    end
    checks++;
    if (hex_a !== 32'h0) begin
      errors++; $display("FAIL reset_hex got %h need 0", hex_a);
    end
    reset = 1'b1;
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic er; int lat;
    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, rd, er, lat);
    checks++;
    if (lat !== 3 || er !== 1'b0 || rd !== 32'h0) begin
      errors++; $display("FAIL wr_0x10 got lat=%0d err=%b rd=%h need 3 0 0", lat, er, rd);
    end
    txn(0, 1'b0, 32'h10, 32'h0, rd, er, lat);
    checks++;
    if (lat !== 3 || er !== 1'b0) begin
      errors++; $display("FAIL rd_0x10_lat got lat=%0d err=%b need 3 0", lat, er);
    end
    checks++;
    if (rd !== 32'hDEADBEEF) begin
      errors++; $display("FAIL rd_0x10_data got %h need deadbeef", rd);
    end
  endtask

  task automatic test_busy();
    logic [7:0] rdy, rsp, bsy;
    logic [31:0] d3 = '0;
    @(negedge clk);
    t_we = 1'b0; t_addr = 32'h10; valid_a = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      rdy[i] = if_a.req_ready;
      rsp[i] = if_a.rsp_valid;
      bsy[i] = if_a.busy;
      if (i == 3) d3 = if_a.rsp_rdata;
    end
    valid_a = 1'b0;
    checks++;
    if (rdy !== 8'b0001_0001) begin
      errors++; $display("FAIL busy_ready_pattern got %b need 00010001", rdy);
    end
    checks++;
    if (rsp !== 8'b1000_1000) begin
      errors++; $display("FAIL busy_rsp_pattern got %b need 10001000", rsp);
    end
    checks++;
    if (bsy !== 8'b1110_1110) begin
      errors++; $display("FAIL busy_busy_pattern got %b need 11101110", bsy);
    end
    checks++;
    if (d3 !== 32'hDEADBEEF) begin
      errors++; $display("FAIL busy_rdata got %h need deadbeef", d3);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat;
    txn(0, 1'b0, 32'h13, 32'h0, rd, er, lat);
    checks++;
    if (lat !== 3 || er !== 1'b1 || rd !== 32'h0) begin
      errors++; $display("FAIL misaligned_rd got lat=%0d err=%b rd=%h need 3 1 0", lat, er, rd);
    end
    txn(0, 1'b1, 32'h0, 32'h11111111, rd, er, lat);
    checks++;
    if (er !== 1'b0) begin
      errors++; $display("FAIL wr_word0 got err=%b need 0", er);
    end
    txn(0, 1'b1, 32'd256, 32'h00000BAD, rd, er, lat);
    checks++;
    if (lat !== 3 || er !== 1'b1 || rd !== 32'h0) begin
      errors++; $display("FAIL oor_wr got lat=%0d err=%b rd=%h need 3 1 0", lat, er, rd);
    end
    txn(0, 1'b0, 32'h0, 32'h0, rd, er, lat);
    checks++;
    if (er !== 1'b0 || rd !== 32'h11111111) begin
      errors++; $display("FAIL word0_after_oor got err=%b rd=%h need 0 11111111", er, rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int lat;
    logic [5:0] rdy, rsp;
    txn(1, 1'b1, 32'h8, 32'hCAFEF00D, rd, er, lat);
    checks++;
    if (lat !== 1 || er !== 1'b0) begin
      errors++; $display("FAIL w0_wr got lat=%0d err=%b need 1 0", lat, er);
    end
    txn(1, 1'b0, 32'h8, 32'h0, rd, er, lat);
    checks++;
    if (lat !== 1 || er !== 1'b0 || rd !== 32'hCAFEF00D) begin
      errors++; $display("FAIL w0_rd got lat=%0d err=%b rd=%h need 1 0 cafef00d", lat, er, rd);
    end
    @(negedge clk);
    t_we = 1'b0; t_addr = 32'h8; valid_b = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      rdy[i] = if_b.req_ready;
      rsp[i] = if_b.rsp_valid;
    end
    valid_b = 1'b0;
    checks++;
    if (rdy !== 6'b010101 || rsp !== 6'b101010) begin
      errors++; $display("FAIL w0_b2b got rdy=%b rsp=%b need 010101 101010", rdy, rsp);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int lat;
    txn(0, 1'b1, 32'h20, 32'h00000001, rd, er, lat);
    @(negedge clk);
    t_we = 1'b1; t_addr = 32'h20; t_wdata = 32'hFFFFFFFF; valid_a = 1'b1;
    @(negedge clk);
    valid_a = 1'b0;
    checks++;
    if (if_a.busy !== 1'b1) begin
      errors++; $display("FAIL mid_busy_before_reset got %b need 1", if_a.busy);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({if_a.req_ready, if_a.busy, if_a.rsp_valid, if_a.rsp_err} !== 4'b1000 ||
        if_a.rsp_rdata !== 32'h0 || hex_a !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset_outputs got {rdy,busy,rv,err}=%b rd=%h hex=%h need 1000 0 0",
               {if_a.req_ready, if_a.busy, if_a.rsp_valid, if_a.rsp_err},
               if_a.rsp_rdata, hex_a);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    txn(0, 1'b0, 32'h20, 32'h0, rd, er, lat);
    checks++;
    if (er !== 1'b0 || rd !== 32'h00000001) begin
      errors++; $display("FAIL mid_no_commit got err=%b rd=%h need 0 00000001", er, rd);
    end
  endtask

  task automatic test_mmio();
    logic [31:0] rd; logic er; int lat;
    sw_in = 4'b1010;
    txn(0, 1'b0, 32'hFFFF_0000, 32'h0, rd, er, lat);
    checks++;
`ifdef DMEM_MMIO_EN
    if (er !== 1'b0 || rd !== 32'h0000000A) begin
      errors++; $display("FAIL mmio_sw_rd got err=%b rd=%h need 0 0000000a", er, rd);
    end
`else
    if (er !== 1'b1 || rd !== 32'h0) begin
      errors++; $display("FAIL mmio_sw_rd got err=%b rd=%h need 1 0", er, rd);
    end
`endif
    txn(0, 1'b1, 32'hFFFF_0004, 32'h12345678, rd, er, lat);
    checks++;
`ifdef DMEM_MMIO_EN
    if (er !== 1'b0 || hex_a !== 32'h12345678) begin
      errors++; $display("FAIL mmio_hex_wr got err=%b hex=%h need 0 12345678", er, hex_a);
    end
`else
    if (er !== 1'b1 || hex_a !== 32'h0) begin
      errors++; $display("FAIL mmio_hex_wr got err=%b hex=%h need 1 0", er, hex_a);
    end
`endif
    txn(0, 1'b0, 32'hFFFF_0004, 32'h0, rd, er, lat);
    checks++;
`ifdef DMEM_MMIO_EN
    if (er !== 1'b0 || rd !== 32'h12345678) begin
      errors++; $display("FAIL mmio_hex_rd got err=%b rd=%h need 0 12345678", er, rd);
    end
`else
    if (er !== 1'b1 || rd !== 32'h0) begin
      errors++; $display("FAIL mmio_hex_rd got err=%b rd=%h need 1 0", er, rd);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_busy();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    test_mmio();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
